// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller: access size codes,
// sign-extension bit position, FSM state encoding and the alignment check.
package dmem_pkg;

    localparam logic [2:0] SIZE_BYTE = 3'b001;
    localparam logic [2:0] SIZE_HALF = 3'b011;
    localparam logic [2:0] SIZE_WORD = 3'b111;

    localparam int SIGN_BIT = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        CAP,
        WR,
        RESP,
        ERR
    } state_t;

    // An access is rejected for an unknown size code or when it is not
    // naturally aligned to its own size.
    function automatic logic is_illegal(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return (addr_lo != 2'b00);
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/memory_multiplexer.sv
// Byte-lane steering between a RAM word and the core: extracts and extends
// load data, and merges right-aligned store data into the old word.
module memory_multiplexer
    import dmem_pkg::*;
(
    input  logic [31:0] i_word_buf,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_sign_mask,
    output logic [31:0] o_read_buf,
    output logic [31:0] o_replacement_word
);

    logic [2:0]  w_size;
    logic        w_sign;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_lane_en;

    assign w_size = i_sign_mask[2:0];
    assign w_sign = i_sign_mask[SIGN_BIT];
    assign w_byte = i_word_buf[8*i_addr_lo +: 8];
    assign w_half = i_addr_lo[1] ? i_word_buf[31:16] : i_word_buf[15:0];

    // Load path: pick the addressed byte/halfword and extend it.
    always_comb begin
        case (w_size)
            SIZE_BYTE: o_read_buf = {{24{w_sign & w_byte[7]}}, w_byte};
            SIZE_HALF: o_read_buf = {{16{w_sign & w_half[15]}}, w_half};
            default:   o_read_buf = i_word_buf;
        endcase
    end

    // Store path: each lane takes new data when it is covered by the access,
    // otherwise it keeps the byte read back from memory.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        logic [7:0] w_new_byte;

        assign w_lane_en[gi] = (w_size == SIZE_WORD)
                            || ((w_size == SIZE_HALF) && (i_addr_lo[1] == LANE[1]))
                            || ((w_size == SIZE_BYTE) && (i_addr_lo == LANE));

        assign w_new_byte = (w_size == SIZE_WORD) ? i_wdata[8*gi +: 8]
                          : (w_size == SIZE_HALF) ? (LANE[0] ? i_wdata[15:8] : i_wdata[7:0])
                          : i_wdata[7:0];

        assign o_replacement_word[8*gi +: 8] = w_lane_en[gi] ? w_new_byte : i_word_buf[8*gi +: 8];
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences core loads/stores onto a single-port synchronous-read word RAM.
// Word stores go straight to memory, sub-word stores use read-modify-write,
// loads return extracted and extended data, misaligned accesses are refused.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 1
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_sign_mask,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

    state_t                r_state;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_sign_mask;
    logic                  r_we;
    logic [31:0]           r_word_buf;
    logic [31:0]           r_rsp_rdata;
    logic [1:0]            r_cnt;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic                  r_mem_re;
    logic                  r_mem_we;

    logic                  w_accept;
    logic                  w_illegal;
    logic                  w_word_store;
    logic [31:0]           w_read_buf;
    logic [31:0]           w_replacement;
    logic                  w_unused_addr;

    assign w_accept      = req_valid & r_req_ready;
    assign w_illegal     = is_illegal(req_sign_mask[2:0], req_addr[1:0]);
    assign w_word_store  = req_we & (req_sign_mask[2:0] == SIZE_WORD);
    // Byte-address bits above the RAM range are deliberately dropped.
    assign w_unused_addr = ^req_addr[31:ADDR_WIDTH+2];

    memory_multiplexer u_mux (
        .i_word_buf         (r_word_buf),
        .i_addr_lo          (r_addr[1:0]),
        .i_wdata            (r_wdata),
        .i_sign_mask        (r_sign_mask),
        .o_read_buf         (w_read_buf),
        .o_replacement_word (w_replacement)
    );

    // Transaction FSM: strobes are registered on the edge entering the state
    // that owns them, so each one is high for exactly that state's cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_sign_mask <= '0;
            r_we        <= 1'b0;
            r_word_buf  <= '0;
            r_rsp_rdata <= '0;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_addr      <= req_addr[ADDR_WIDTH+1:0];
                        r_wdata     <= req_wdata;
                        r_sign_mask <= req_sign_mask;
                        r_we        <= req_we;
                        r_req_ready <= 1'b0;
                        if (w_illegal) begin
                            r_state     <= ERR;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else if (w_word_store) begin
                            r_state     <= WR;
                            r_mem_we    <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_state  <= RD;
                            r_mem_re <= 1'b1;
                        end
                    end
                end
                RD: begin
                    r_cnt <= LAT_LOAD;
                    if (READ_LATENCY == 1) begin
                        r_state <= CAP;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 2'd1;
                    if (r_cnt <= 2'd1) begin
                        r_state <= CAP;
                    end
                end
                CAP: begin
                    r_word_buf  <= mem_rdata;
                    r_rsp_valid <= 1'b1;
                    if (r_we) begin
                        r_state     <= WR;
                        r_mem_we    <= 1'b1;
                        r_rsp_rdata <= '0;
                    end else begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    // Keep the load result visible until the next response.
                    r_rsp_rdata <= w_read_buf;
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
                WR, ERR: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr[ADDR_WIDTH+1:2];

    // Merged data depends on word_buf, which is loaded on the edge entering
    // WR/RESP, so the data paths are decoded from the registered state.
    always_comb begin
        rsp_rdata = (r_state == RESP) ? w_read_buf : r_rsp_rdata;
        mem_wdata = '0;
        if (r_state == WR) begin
            mem_wdata = (r_sign_mask[2:0] == SIZE_WORD) ? r_wdata : w_replacement;
        end
    end

endmodule
